// File: rtl/csa_adder_pkg.sv
// rtl/csa_adder_pkg.sv - shared types for the pipelined carry-select adder/subtractor
//   op_t        : operation select, OP_ADD / OP_SUB
//   cand_bit_t  : one-bit stage-1 value held for both possible block carry-ins
package csa_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // c0: value assuming carry-in 0, c1: value assuming carry-in 1
  typedef struct packed {
    logic c0;
    logic c1;
  } cand_bit_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_block.sv
// rtl/rca_block.sv - BLOCK-bit ripple-carry adder built from full_adder cells
//   a, b    : BLOCK-bit addends
//   cin     : carry into bit 0
//   sum     : BLOCK-bit sum
//   cout    : carry out of the top bit
//   msb_cin : carry into the top bit (used for signed overflow)
module rca_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [BLOCK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign cout    = carry[BLOCK];
  assign msb_cin = carry[BLOCK-1];

endmodule

// File: rtl/csa_adder_pipe.sv
// rtl/csa_adder_pipe.sv - two-stage pipelined carry-select adder/subtractor with valid/ready
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      : operand beat handshake; in_a, in_b, in_op (0 add, 1 sub), in_cin
//   out_valid/out_ready    : result beat handshake; out_sum, out_cout (raw carry-out)
//   out_ovf, out_zero      : signed overflow and zero result, present only with CSA_ADDER_PIPE_FLAGS_EN
module csa_adder_pipe
  import csa_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CSA_ADDER_PIPE_FLAGS_EN
  ,
  output logic             out_ovf,
  output logic             out_zero
`endif
);

  localparam int N = WIDTH / BLOCK;

  // Effective operands: subtract is a + ~b + 1, in_cin only matters for add
  op_t              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign op    = op_t'(in_op);
  assign b_eff = (op == OP_SUB) ? ~in_b : in_b;
  assign c0    = (op == OP_SUB) ? 1'b1 : in_cin;

  // Stage 1 combinational: block 0 resolved, upper blocks for both carry-ins
  logic [BLOCK-1:0]             blk0_sum;
  logic                         blk0_cout;
  logic                         blk0_msb;
  logic [N-1:1][1:0][BLOCK-1:0] cand_sum;
  cand_bit_t [N-1:1]            cand_cout;
  cand_bit_t [N-1:1]            cand_msb;

  rca_block #(.BLOCK(BLOCK)) u_rca_blk0 (
    .a       (in_a[BLOCK-1:0]),
    .b       (b_eff[BLOCK-1:0]),
    .cin     (c0),
    .sum     (blk0_sum),
    .cout    (blk0_cout),
    .msb_cin (blk0_msb)
  );

  for (genvar i = 1; i < N; i++) begin : g_blk
    logic [BLOCK-1:0] sum_c0, sum_c1;
    logic             co_c0, co_c1, mc_c0, mc_c1;

    rca_block #(.BLOCK(BLOCK)) u_rca_c0 (
      .a       (in_a[i*BLOCK +: BLOCK]),
      .b       (b_eff[i*BLOCK +: BLOCK]),
      .cin     (1'b0),
      .sum     (sum_c0),
      .cout    (co_c0),
      .msb_cin (mc_c0)
    );

    rca_block #(.BLOCK(BLOCK)) u_rca_c1 (
      .a       (in_a[i*BLOCK +: BLOCK]),
      .b       (b_eff[i*BLOCK +: BLOCK]),
      .cin     (1'b1),
      .sum     (sum_c1),
      .cout    (co_c1),
      .msb_cin (mc_c1)
    );

    assign cand_sum[i][0] = sum_c0;
    assign cand_sum[i][1] = sum_c1;
    assign cand_cout[i]   = '{c0: co_c0, c1: co_c1};
    assign cand_msb[i]    = '{c0: mc_c0, c1: mc_c1};
  end

  // Only the top block's MSB carry-in feeds overflow; the rest are by-products
  logic unused_msb;
  assign unused_msb = ^{blk0_msb, cand_msb};

  // Pipeline control: S2 takes a new beat when empty or draining this cycle
  logic s1_valid;
  logic s2_load;
  logic in_fire;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // S1 payload
  logic [BLOCK-1:0]             s1_sum0;
  logic                         s1_c0;
  logic [N-1:1][1:0][BLOCK-1:0] s1_cand_sum;
  cand_bit_t [N-1:1]            s1_cand_cout;
`ifdef CSA_ADDER_PIPE_FLAGS_EN
  cand_bit_t                    s1_top_msb;
`endif

  // Stage 2 select chain: each resolved carry picks the next block's candidate
  logic [WIDTH-1:0] sel_sum;
  logic             sel_cout;
`ifdef CSA_ADDER_PIPE_FLAGS_EN
  logic             sel_msb;
`endif

  always_comb begin
    logic carry;
    sel_sum            = '0;
    sel_sum[BLOCK-1:0] = s1_sum0;
    carry              = s1_c0;
`ifdef CSA_ADDER_PIPE_FLAGS_EN
    sel_msb            = 1'b0;
`endif
    for (int i = 1; i < N; i++) begin
`ifdef CSA_ADDER_PIPE_FLAGS_EN
      if (i == N-1) sel_msb = carry ? s1_top_msb.c1 : s1_top_msb.c0;
`endif
      sel_sum[i*BLOCK +: BLOCK] = carry ? s1_cand_sum[i][1] : s1_cand_sum[i][0];
      carry                     = carry ? s1_cand_cout[i].c1 : s1_cand_cout[i].c0;
    end
    sel_cout = carry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef CSA_ADDER_PIPE_FLAGS_EN
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
`endif
    end else begin
      if (in_fire) begin
        s1_sum0      <= blk0_sum;
        s1_c0        <= blk0_cout;
        s1_cand_sum  <= cand_sum;
        s1_cand_cout <= cand_cout;
`ifdef CSA_ADDER_PIPE_FLAGS_EN
        s1_top_msb   <= cand_msb[N-1];
`endif
      end

      if (in_fire)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;

      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sum  <= sel_sum;
          out_cout <= sel_cout;
`ifdef CSA_ADDER_PIPE_FLAGS_EN
          out_ovf  <= sel_msb ^ sel_cout;
          out_zero <= (sel_sum == '0);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_adder_pipe.sv
// tb/tb_csa_adder_pipe.sv - self-checking bench for csa_adder_pipe against an arithmetic reference model
module tb_csa_adder_pipe;

  localparam int WIDTH = 32;
  localparam int BLOCK = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CSA_ADDER_PIPE_FLAGS_EN
  logic             out_ovf;
  logic             out_zero;
`endif

  csa_adder_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef CSA_ADDER_PIPE_FLAGS_EN
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
`endif
    .out_cout  (out_cout)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          t;
  } exp_t;

  exp_t exp_q[$];

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic op, input logic cin);
    exp_t        r;
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    longint      exact;
    if (op) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      exact  = sa - sb;
    end else begin
      r.sum  = a + b + 32'(cin);
      r.cout = (ua + ub + longint'(cin)) > 64'h0000_0000_FFFF_FFFF;
      exact  = sa + sb + longint'(cin);
    end
    r.ovf  = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    r.zero = (r.sum == 32'h0);
    r.t    = 0;
    return r;
  endfunction

  // Monitor: pipeline occupancy and latency predicted from the model queue
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_sum;
  logic        prev_cout;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      stalled_prev = 1'b0;
    end else begin
      check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      check("out_valid", out_valid, (exp_q.size() > 0) && (cyc >= exp_q[0].t + 2));
      if (out_valid && exp_q.size() > 0) begin
        check("out_sum", out_sum, exp_q[0].sum);
        check("out_cout", out_cout, exp_q[0].cout);
`ifdef CSA_ADDER_PIPE_FLAGS_EN
        check("out_ovf", out_ovf, exp_q[0].ovf);
        check("out_zero", out_zero, exp_q[0].zero);
`endif
      end
      if (stalled_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_sum", out_sum, prev_sum);
        check("hold_cout", out_cout, prev_cout);
      end
      stalled_prev = out_valid && !out_ready;
      prev_sum     = out_sum;
      prev_cout    = out_cout;
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_t e;
        e   = model(in_a, in_b, in_op, in_cin);
        e.t = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input logic cin);
    logic fired;
    int   n = 0;
    in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
    forever begin
      @(negedge clock);
      fired = in_ready;
      @(posedge clock);
      #1;
      if (fired) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Pin the reference model to hand-worked values, then run the beat through the DUT
  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic cin, input logic [31:0] esum,
                          input logic ecout, input logic eovf, input logic ezero);
    exp_t m;
    m = model(a, b, op, cin);
    check({name, "_model_sum"}, m.sum, esum);
    check({name, "_model_cout"}, m.cout, ecout);
    check({name, "_model_ovf"}, m.ovf, eovf);
    check({name, "_model_zero"}, m.zero, ezero);
    send(a, b, op, cin);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_cin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_cout", out_cout, 1'b0);
`ifdef CSA_ADDER_PIPE_FLAGS_EN
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_zero", out_zero, 1'b0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;

    // Directed arithmetic cases
    directed("carry_all",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("cross_blk",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0101, 1'b0, 1'b0, 1'b0);
    directed("add_ovf",    32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub_cin0",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    drain();

    // Backpressure: four back-to-back beats, consumer stalled for three cycles
    @(posedge clock); #1;
    out_ready = 1'b0;
    fork
      begin
        send(32'd1, 32'd2, 1'b0, 1'b0);
        send(32'd10, 32'd3, 1'b1, 1'b0);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        send(32'd0, 32'd1, 1'b1, 1'b0);
      end
      begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_head_valid", out_valid, 1'b1);
        check("bp_head_sum", out_sum, 32'd3);
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Throughput: 100 random beats, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++)
      send(pick(), pick(), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
    drain();

    // Random backpressure with random operands
    begin
      logic done = 1'b0;
      fork
        begin
          for (int i = 0; i < 150; i++)
            send(pick(), pick(), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clock); #1;
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
    end
    drain();

    // Reset mid-stream with the pipeline full
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    send(32'h0000_0009, 32'h0000_0004, 1'b1, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_sum", out_sum, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("mid_rst_in_ready", in_ready, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    check("mid_rst_no_stale", out_valid, 1'b0);
    directed("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
